// File: rtl/auth_sequencer_if.sv
// Bundles the start/result, CRP database and PUF signals of the authentication sequencer.
interface auth_sequencer_if;
  logic        start;
  logic [31:0] chiplet_id_in;
  logic [31:0] db_chiplet_id;
  logic [3:0]  db_query_type;
  logic [15:0] db_challenge;
  logic [3:0]  db_activation;
  logic [15:0] db_response;
  logic        db_valid;
  logic [15:0] puf_challenge;
  logic [3:0]  puf_activation;
  logic        puf_req;
  logic [15:0] puf_resp;
  logic        puf_resp_valid;
  logic        busy;
  logic        done;
  logic [2:0]  status;
  logic [4:0]  hd_out;
  logic [1:0]  attempts;

  modport slave (
    input  start, chiplet_id_in, db_challenge, db_activation, db_response, db_valid,
           puf_resp, puf_resp_valid,
    output db_chiplet_id, db_query_type, puf_challenge, puf_activation, puf_req,
           busy, done, status, hd_out, attempts
  );

  modport master (
    output start, chiplet_id_in, db_challenge, db_activation, db_response, db_valid,
           puf_resp, puf_resp_valid,
    input  db_chiplet_id, db_query_type, puf_challenge, puf_activation, puf_req,
           busy, done, status, hd_out, attempts
  );
endinterface

// File: rtl/auth_sequencer.sv
// Fetches challenge/activation/golden response for one chiplet, drives the PUF and
// grades the reply by Hamming distance with bounded retries on mismatch or timeout.
module auth_sequencer #(
  parameter int unsigned HD_THRESHOLD   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic              clk,
  input  logic              rst,
  auth_sequencer_if.slave   bus
);

  localparam logic [4:0] HD_LIMIT  = 5'(HD_THRESHOLD);
  localparam logic [7:0] TO_LIMIT  = 8'(TIMEOUT_CYCLES);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRIES);

  localparam logic [2:0] ST_NONE    = 3'd0;
  localparam logic [2:0] ST_PASS    = 3'd1;
  localparam logic [2:0] ST_FAIL_HD = 3'd2;
  localparam logic [2:0] ST_FAIL_ID = 3'd3;
  localparam logic [2:0] ST_FAIL_TO = 3'd4;

  typedef enum logic [3:0] {
    IDLE, Q_CHAL, C_CHAL, Q_ACT, C_ACT, Q_RESP, C_RESP,
    PUF_REQ, PUF_WAIT, COMPARE, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] id_q, id_d;
  logic [3:0]  qtype_q, qtype_d;
  logic [15:0] chal_q, chal_d;
  logic [3:0]  act_q, act_d;
  logic [15:0] gold_q, gold_d;
  logic [15:0] resp_q, resp_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        puf_req_q, puf_req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  status_q, status_d;
  logic [4:0]  hd_q, hd_d;
  logic [1:0]  att_q, att_d;
  logic [4:0]  hd_c;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  assign hd_c = popcount16(resp_q ^ gold_q);

  // Next-state and next-output logic; every output is the registered copy of its _d value.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    qtype_d   = qtype_q;
    chal_d    = chal_q;
    act_d     = act_q;
    gold_d    = gold_q;
    resp_d    = resp_q;
    cnt_d     = cnt_q;
    status_d  = status_q;
    hd_d      = hd_q;
    att_d     = att_q;
    puf_req_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          id_d     = bus.chiplet_id_in;
          hd_d     = '0;
          att_d    = '0;
          status_d = ST_NONE;
          qtype_d  = 4'd0;
          state_d  = Q_CHAL;
        end
      end
      Q_CHAL: state_d = C_CHAL;
      C_CHAL: begin
        if (!bus.db_valid) begin
          status_d = ST_FAIL_ID;
          state_d  = DONE;
        end else begin
          chal_d  = bus.db_challenge;
          qtype_d = 4'd1;
          state_d = Q_ACT;
        end
      end
      Q_ACT: state_d = C_ACT;
      C_ACT: begin
        if (!bus.db_valid) begin
          status_d = ST_FAIL_ID;
          state_d  = DONE;
        end else begin
          act_d   = bus.db_activation;
          qtype_d = 4'd2;
          state_d = Q_RESP;
        end
      end
      Q_RESP: state_d = C_RESP;
      C_RESP: begin
        if (!bus.db_valid) begin
          status_d = ST_FAIL_ID;
          state_d  = DONE;
        end else begin
          gold_d  = bus.db_response;
          state_d = PUF_REQ;
        end
      end
      PUF_REQ: begin
        cnt_d   = '0;
        state_d = PUF_WAIT;
      end
      PUF_WAIT: begin
        // A response on the terminal-count cycle still counts as a response.
        if (bus.puf_resp_valid) begin
          resp_d  = bus.puf_resp;
          state_d = COMPARE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TO_LIMIT) begin
            if (att_q <= RETRY_MAX) begin
              state_d = PUF_REQ;
            end else begin
              status_d = ST_FAIL_TO;
              state_d  = DONE;
            end
          end
        end
      end
      COMPARE: begin
        hd_d = hd_c;
        if (hd_c <= HD_LIMIT) begin
          status_d = ST_PASS;
          state_d  = DONE;
        end else if (att_q <= RETRY_MAX) begin
          state_d = PUF_REQ;
        end else begin
          status_d = ST_FAIL_HD;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Request pulse and attempt count line up with the cycle spent in PUF_REQ.
    if (state_d == PUF_REQ) begin
      puf_req_d = 1'b1;
      att_d     = att_q + 2'd1;
    end
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      id_q      <= '0;
      qtype_q   <= '0;
      chal_q    <= '0;
      act_q     <= '0;
      gold_q    <= '0;
      resp_q    <= '0;
      cnt_q     <= '0;
      puf_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= '0;
      hd_q      <= '0;
      att_q     <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      qtype_q   <= qtype_d;
      chal_q    <= chal_d;
      act_q     <= act_d;
      gold_q    <= gold_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
      puf_req_q <= puf_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      status_q  <= status_d;
      hd_q      <= hd_d;
      att_q     <= att_d;
    end
  end

  assign bus.db_chiplet_id  = id_q;
  assign bus.db_query_type  = qtype_q;
  assign bus.puf_challenge  = chal_q;
  assign bus.puf_activation = act_q;
  assign bus.puf_req        = puf_req_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.status         = status_q;
  assign bus.hd_out         = hd_q;
  assign bus.attempts       = att_q;

endmodule

// File: doc/auth_sequencer.md
# auth_sequencer

Authentication sequencer that sits downstream of the CRP database and upstream of the chiplet PUF interface. For one chiplet ID it fetches the enrolled challenge, activation and golden response from the database. It then issues the challenge to the PUF and compares the returned response against the golden value by Hamming distance. It reports pass/fail with a status code, and retries the PUF a bounded number of times on a mismatch or timeout.

## Interface
- HD_THRESHOLD, 2, maximum Hamming distance still accepted as PASS
- TIMEOUT_CYCLES, 255, PUF wait cycles before a timeout; 8-bit counter, range 1..255
- MAX_RETRIES, 2, additional PUF attempts after the first failed one
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin authentication; sampled only in IDLE
- chiplet_id_in  in  32  ID to authenticate; latched on accepted start
- db_chiplet_id  out  32  ID driven to the database
- db_query_type  out  4  0 = challenge, 1 = activation, 2 = response
- db_challenge  in  16  database challenge
- db_activation  in  4  database activation
- db_response  in  16  database golden response
- db_valid  in  1  database hit flag (registered, 1-cycle latency)
- puf_challenge  out  16  challenge to the PUF
- puf_activation  out  4  activation to the PUF
- puf_req  out  1  single-cycle request pulse
- puf_resp  in  16  PUF response
- puf_resp_valid  in  1  response qualifier; one-cycle pulse
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a result is final
- status  out  3  0 none, 1 PASS, 2 FAIL_HD, 3 FAIL_UNKNOWN_ID, 4 FAIL_TIMEOUT
- hd_out  out  5  Hamming distance of the last compare (0..16)
- attempts  out  2  PUF attempts used in the last run (1..MAX_RETRIES+1)

## Operation
- States: IDLE, Q_CHAL, C_CHAL, Q_ACT, C_ACT, Q_RESP, C_RESP, PUF_REQ, PUF_WAIT, COMPARE, DONE.
- IDLE with start high:
  - latch chiplet_id_in into db_chiplet_id;
  - clear hd_out and attempts;
  - set status to 0;
  - go to Q_CHAL.
- Q_x state: drives the matching db_query_type, then goes to C_x. db_query_type and db_chiplet_id are held through C_x.
- C_x state: samples the database at the end of the cycle.
  - db_valid low: status = 3, go to DONE.
  - db_valid high: capture the field into its register, then advance. C_CHAL goes to Q_ACT, C_ACT goes to Q_RESP, C_RESP goes to PUF_REQ.
- PUF_REQ: puf_req high for exactly one cycle; increment attempts; clear the timeout counter; go to PUF_WAIT.
  - puf_challenge and puf_activation come from the captured registers.
  - Both hold the captured values from C_CHAL/C_ACT until the next start.
- PUF_WAIT:
  - puf_resp_valid high: capture puf_resp, go to COMPARE.
  - Otherwise, counter reaching TIMEOUT_CYCLES counts as a timeout failure.
  - A response and the terminal count in the same cycle: the response wins.
- COMPARE: hd_out = popcount(puf_resp_captured XOR golden), computed as a full 5-bit result with no truncation.
  - hd_out ≤ HD_THRESHOLD: status = 1, go to DONE.
  - Otherwise a failure.
- Failure handling, for either timeout or HD mismatch:
  - attempts ≤ MAX_RETRIES: go back to PUF_REQ.
  - Otherwise: status = 4 (timeout) or 2 (HD), go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE. status, hd_out and attempts hold until the next accepted start.
- start outside IDLE is ignored. puf_resp_valid outside PUF_WAIT is ignored.

## Timing
- Reset values (immediate, asynchronous):
  - state IDLE;
  - all outputs 0, including db_chiplet_id, db_query_type, puf_* and status.
- Start accepted at edge E0. Q_CHAL runs E0–E1, C_CHAL samples at E2.
- Each field takes 2 cycles, so the database phase is 6 cycles (E0..E6).
- Cycle numbering: puf_req is high in the cycle after E6 (cycle 7).
- A PUF response arriving k cycles after puf_req gives COMPARE one cycle later and done one cycle after that.
- Unknown ID: done is high in cycle 3 after start.
- Timeout: puf_req is first high at cycle 7; each attempt adds 1 + TIMEOUT_CYCLES cycles before the next puf_req or DONE.
- busy rises the cycle after the accepted start and falls when DONE is exited.
- A start and done in the same cycle: start is ignored, because the block is not in IDLE.
- Reset mid-run aborts immediately. No done pulse is generated, and the status of the aborted run is lost.

## Test plan
- Known ID with exact response. Stimulus: id 0x00007f6d; database returns 0x1433/0x9/0x02BE; puf_resp = 0x02BE two cycles after puf_req. Required: puf_challenge = 0x1433, puf_activation = 0x9, status = 1, hd_out = 0, attempts = 1, a single done pulse.
- Within threshold. Stimulus: same ID, puf_resp = 0x02BC. Required: hd_out = 1, status = 1.
- Mismatch with retries. Stimulus: puf_resp = 0x02B1 on every attempt. Required: hd_out = 4, three puf_req pulses, attempts = 3, status = 2.
- Unknown ID. Stimulus: id 0x12345678 with db_valid low. Required: status = 3, done in cycle 3 after start, no puf_req.
- Timeout, then recovery. Stimulus: TIMEOUT_CYCLES = 8; PUF silent on the first attempt, returns 0x02BE on the second. Required: status = 1, attempts = 2, gap between the two puf_req pulses = 9 cycles.
- Reset in PUF_WAIT. Stimulus: rst high mid-wait. Required: all outputs 0 immediately, no done pulse. A new start after rst is released completes normally.
